// File: rtl/npc_ctrl_pkg.sv
// Shared control constants for the NPC multi-cycle core: FSM state encoding,
// RV32I major opcodes, halt cause codes and the opcode-class record.
package npc_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IF_REQ   = 3'd0,
      ST_IF_WAIT  = 3'd1,
      ST_ID       = 3'd2,
      ST_EX       = 3'd3,
      ST_MEM_REQ  = 3'd4,
      ST_MEM_WAIT = 3'd5,
      ST_WB       = 3'd6,
      ST_HALT     = 3'd7
   } state_t;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef enum logic [1:0] {
      HC_NONE    = 2'd0,
      HC_EBREAK  = 2'd1,
      HC_ILLEGAL = 2'd2,
      HC_TIMEOUT = 2'd3
   } halt_cause_t;

   typedef struct packed {
      logic legal;
      logic is_mem;
      logic writes_rd;
      logic is_trap;
   } opclass_t;

endpackage

// File: rtl/npc_opclass.sv
// Combinational opcode classifier, shared between the sequencer and the decoder.
module npc_opclass
   import npc_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   output opclass_t   cls
);

   always_comb begin
      cls = '0;
      case (opcode)
         OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_OPIMM, OP_OP: begin
            cls.legal     = 1'b1;
            cls.writes_rd = 1'b1;
         end
         OP_LOAD: begin
            cls.legal     = 1'b1;
            cls.is_mem    = 1'b1;
            cls.writes_rd = 1'b1;
         end
         OP_STORE: begin
            cls.legal  = 1'b1;
            cls.is_mem = 1'b1;
         end
         OP_BRANCH: cls.legal = 1'b1;
         // Any SYSTEM encoding stops the core; there is no CSR support.
         OP_SYSTEM: cls.is_trap = 1'b1;
         default: cls = '0;
      endcase
   end

endmodule

// File: rtl/npc_exec_sequencer.sv
// Multi-cycle fetch/decode/memory/commit sequencer with halt handling,
// a memory-wait watchdog and cycle/instret performance counters.
module npc_exec_sequencer
   import npc_ctrl_pkg::*;
#(
   parameter int CNT_W   = 64,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   output logic             imem_req_valid,
   input  logic             imem_req_ready,
   input  logic             imem_rsp_valid,
   input  logic [31:0]      imem_rsp_inst,
   output logic [31:0]      ir,
   output logic             dmem_req_valid,
   input  logic             dmem_req_ready,
   input  logic             dmem_rsp_valid,
   output logic             pc_we,
   output logic             rf_we,
   output logic [2:0]       state,
   output logic             halt,
   output logic [1:0]       halt_cause,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt
);

   localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t           state_q, state_d;
   halt_cause_t      cause_q, cause_d;
   logic [31:0]      ir_q;
   logic [WD_W-1:0]  wd_q;
   logic [CNT_W-1:0] cycle_q, instret_q;
   opclass_t         cls;
   logic             wd_hit;
   logic             waiting;

   npc_opclass u_opclass (
      .opcode (ir_q[6:0]),
      .cls    (cls)
   );

   assign waiting = (state_q == ST_IF_WAIT) || (state_q == ST_MEM_WAIT);
   // Last permitted wait cycle; a response arriving in it still wins.
   assign wd_hit  = (wd_q == WD_W'(TIMEOUT - 1));

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      case (state_q)
         ST_IF_REQ:   if (imem_req_ready) state_d = ST_IF_WAIT;
         ST_IF_WAIT: begin
            if (imem_rsp_valid) begin
               state_d = ST_ID;
            end else if (wd_hit) begin
               state_d = ST_HALT;
               cause_d = HC_TIMEOUT;
            end
         end
         ST_ID: begin
            if (cls.is_trap) begin
               state_d = ST_HALT;
               cause_d = HC_EBREAK;
            end else if (!cls.legal) begin
               state_d = ST_HALT;
               cause_d = HC_ILLEGAL;
            end else begin
               state_d = ST_EX;
            end
         end
         ST_EX:       state_d = cls.is_mem ? ST_MEM_REQ : ST_WB;
         ST_MEM_REQ:  if (dmem_req_ready) state_d = ST_MEM_WAIT;
         ST_MEM_WAIT: begin
            if (dmem_rsp_valid) begin
               state_d = ST_WB;
            end else if (wd_hit) begin
               state_d = ST_HALT;
               cause_d = HC_TIMEOUT;
            end
         end
         ST_WB:       state_d = ST_IF_REQ;
         ST_HALT:     state_d = ST_HALT;
         default:     state_d = ST_IF_REQ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_IF_REQ;
         cause_q   <= HC_NONE;
         ir_q      <= '0;
         wd_q      <= '0;
         cycle_q   <= '0;
         instret_q <= '0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         if (state_q == ST_IF_WAIT && imem_rsp_valid)
            ir_q <= imem_rsp_inst;
         if (state_d != state_q)
            wd_q <= '0;
         else if (waiting)
            wd_q <= wd_q + WD_W'(1);
         if (state_q != ST_HALT)
            cycle_q <= cycle_q + CNT_W'(1);
         if (state_q == ST_WB)
            instret_q <= instret_q + CNT_W'(1);
      end
   end

   // Outputs decode the registered state only; rst gating keeps them quiet in reset.
   assign imem_req_valid = rst && (state_q == ST_IF_REQ);
   assign dmem_req_valid = rst && (state_q == ST_MEM_REQ);
   assign pc_we          = rst && (state_q == ST_WB);
   assign rf_we          = rst && (state_q == ST_WB) && cls.writes_rd;
   assign state          = state_q;
   assign halt           = (state_q == ST_HALT);
   assign halt_cause     = cause_q;
   assign ir             = ir_q;
   assign cycle_cnt      = cycle_q;
   assign instret_cnt    = instret_q;

endmodule

// File: tb/tb_npc_exec_sequencer.sv
// Randomized bench for npc_exec_sequencer against a timeline model of the
// instruction phases (per-phase durations summed into expected cycle numbers).
module tb_npc_exec_sequencer;
   import npc_ctrl_pkg::*;

   localparam int CNT_W   = 64;
   localparam int TIMEOUT = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             imem_req_valid, imem_req_ready, imem_rsp_valid;
   logic [31:0]      imem_rsp_inst, ir;
   logic             dmem_req_valid, dmem_req_ready, dmem_rsp_valid;
   logic             pc_we, rf_we, halt;
   logic [2:0]       state;
   logic [1:0]       halt_cause;
   logic [CNT_W-1:0] cycle_cnt, instret_cnt;

   int vecs = 0;
   int errs = 0;
   longint unsigned m_cyc, m_ret;
   logic [31:0] m_ir;
   logic [6:0]  ops [9] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                            7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};

   always #5 clk = ~clk;

   npc_exec_sequencer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_inst(imem_rsp_inst), .ir(ir),
      .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
      .dmem_rsp_valid(dmem_rsp_valid), .pc_we(pc_we), .rf_we(rf_we),
      .state(state), .halt(halt), .halt_cause(halt_cause),
      .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
   );

   function automatic void classify(input logic [6:0] op, output bit mem, output bit wr,
                                    output bit trap, output bit ill);
      bit sup;
      sup = 1'b0;
      for (int i = 0; i < 9; i++) if (ops[i] == op) sup = 1'b1;
      trap = (op == 7'b1110011);
      ill  = !trap && !sup;
      mem  = (op == 7'b0000011) || (op == 7'b0100011);
      wr   = sup && !(op == 7'b1100011 || op == 7'b0100011);
   endfunction

   function automatic logic [31:0] rand_inst(input logic [6:0] op);
      logic [31:0] r;
      r = $urandom;
      return {r[31:7], op};
   endfunction

   task automatic idle_inputs();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_inst  = 32'h0;
      dmem_req_ready = 1'b0;
      dmem_rsp_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      idle_inputs();
      @(negedge clk);
      @(negedge clk);
      vecs++;
      if ({imem_req_valid, dmem_req_valid, pc_we, rf_we} !== 4'b0000) begin
         errs++;
         $display("FAIL rst_outputs got %b want 0000", {imem_req_valid, dmem_req_valid, pc_we, rf_we});
      end
      rst = 1'b1;
      #1;
      vecs++;
      if (state !== ST_IF_REQ || ir !== 32'h0 || halt !== 1'b0 || halt_cause !== 2'd0 ||
          cycle_cnt !== '0 || instret_cnt !== '0 || imem_req_valid !== 1'b1) begin
         errs++;
         $display("FAIL reset_state got st=%0d ir=%h halt=%b cause=%0d cyc=%0d ret=%0d iv=%b want 0/0/0/0/0/0/1",
                  state, ir, halt, halt_cause, cycle_cnt, instret_cnt, imem_req_valid);
      end
      m_cyc = 0;
      m_ret = 0;
      m_ir  = 32'h0;
   endtask

   // ri: IF_REQ wait before ready; rs: IF_WAIT index of the response (>=TIMEOUT never);
   // dri/drs likewise for dmem; junk drives an ebreak response on the accept cycle.
   task automatic run_instr(input logic [31:0] inst, input int ri, input int rs,
                            input int dri, input int drs, input bit junk, input int abort_at);
      bit mem, wr, trap, ill, tmo, want_pc, want_dv;
      int c_id, mreq_end, mwait_end, wb, n;
      classify(inst[6:0], mem, wr, trap, ill);
      tmo       = (rs >= TIMEOUT);
      c_id      = ri + rs + 3;
      mreq_end  = c_id + 2 + dri;
      mwait_end = mreq_end + 1 + drs;
      wb        = mem ? mwait_end + 1 : c_id + 2;
      if (tmo)             n = ri + 1 + TIMEOUT;
      else if (trap || ill) n = c_id;
      else                 n = wb;
      for (int c = 1; c <= n; c++) begin
         want_pc = !tmo && !trap && !ill && (c == wb);
         want_dv = mem && !tmo && (c >= c_id + 2) && (c <= mreq_end);
         vecs++;
         if (pc_we !== want_pc || rf_we !== (want_pc && wr)) begin
            errs++;
            $display("FAIL strobes inst=%h cyc=%0d got pc=%b rf=%b want pc=%b rf=%b",
                     inst, c, pc_we, rf_we, want_pc, want_pc && wr);
         end
         vecs++;
         if (imem_req_valid !== (c <= ri + 1) || dmem_req_valid !== want_dv || halt !== 1'b0) begin
            errs++;
            $display("FAIL handshake inst=%h cyc=%0d got iv=%b dv=%b halt=%b want iv=%b dv=%b halt=0",
                     inst, c, imem_req_valid, dmem_req_valid, halt, (c <= ri + 1), want_dv);
         end
         if (c == abort_at) begin
            rst = 1'b0;
            idle_inputs();
            return;
         end
         imem_req_ready = (c == ri + 1);
         imem_rsp_valid = !tmo && (c == ri + 2 + rs);
         imem_rsp_inst  = imem_rsp_valid ? inst : $urandom;
         if (junk && c == ri + 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_inst  = 32'h0010_0073;
         end
         dmem_req_ready = mem && (c == mreq_end);
         dmem_rsp_valid = mem && (c == mwait_end);
         @(negedge clk);
         m_cyc++;
      end
      idle_inputs();
      if (tmo || trap || ill) begin
         if (!tmo) m_ir = inst;
         vecs++;
         if (halt !== 1'b1 || halt_cause !== (tmo ? 2'd3 : trap ? 2'd1 : 2'd2) || state !== ST_HALT ||
             cycle_cnt !== m_cyc || ir !== m_ir || pc_we !== 1'b0) begin
            errs++;
            $display("FAIL halt_entry inst=%h got halt=%b cause=%0d st=%0d cyc=%0d ir=%h want 1/%0d/7/%0d/%h",
                     inst, halt, halt_cause, state, cycle_cnt, ir,
                     (tmo ? 3 : trap ? 1 : 2), m_cyc, m_ir);
         end
      end else begin
         m_ret++;
         m_ir = inst;
         vecs++;
         if (state !== ST_IF_REQ || instret_cnt !== m_ret || cycle_cnt !== m_cyc || ir !== inst) begin
            errs++;
            $display("FAIL commit inst=%h got st=%0d ret=%0d cyc=%0d ir=%h want 0/%0d/%0d/%h",
                     inst, state, instret_cnt, cycle_cnt, ir, m_ret, m_cyc, inst);
         end
      end
   endtask

   task automatic check_frozen(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         imem_req_ready = 1'($urandom);
         imem_rsp_valid = 1'($urandom);
         imem_rsp_inst  = $urandom;
         dmem_req_ready = 1'($urandom);
         dmem_rsp_valid = 1'($urandom);
         @(negedge clk);
         vecs++;
         if (cycle_cnt !== m_cyc || halt !== 1'b1 || ir !== m_ir ||
             {pc_we, rf_we, imem_req_valid, dmem_req_valid} !== 4'b0000) begin
            errs++;
            $display("FAIL halt_frozen i=%0d got cyc=%0d halt=%b ir=%h strb=%b want %0d/1/%h/0000",
                     i, cycle_cnt, halt, ir, {pc_we, rf_we, imem_req_valid, dmem_req_valid}, m_cyc, m_ir);
         end
      end
      idle_inputs();
   endtask

   task automatic test_reset();
      do_reset();
   endtask

   task automatic test_alu();
      run_instr(32'h0050_0093, 0, 0, 0, 0, 1'b0, 0);
      for (int i = 0; i < 12; i++) begin
         logic [6:0] op;
         op = ops[$urandom_range(8)];
         if (op == 7'b0000011 || op == 7'b0100011) op = 7'b0110011;
         run_instr(rand_inst(op), $urandom_range(3), $urandom_range(4), 0, 0, 1'($urandom), 0);
      end
      run_instr(32'h0000_0063, 0, 0, 0, 0, 1'b0, 0);
   endtask

   task automatic test_mem();
      run_instr(32'h0000_A103, 0, 0, 3, 2, 1'b0, 0);
      run_instr(32'h0000_A103, 0, 0, 0, 0, 1'b0, 0);
      run_instr(32'h0020_A023, 0, 0, 0, 0, 1'b0, 0);
      run_instr(32'h0020_A023, 1, 15, 0, 15, 1'b1, 0);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 30; i++)
         run_instr(rand_inst(ops[$urandom_range(8)]), $urandom_range(3), $urandom_range(15),
                   $urandom_range(4), $urandom_range(6), 1'($urandom), 0);
   endtask

   task automatic test_ebreak();
      run_instr(32'h0010_0073, 0, 0, 0, 0, 1'b0, 0);
      check_frozen(20);
      do_reset();
   endtask

   task automatic test_timeout();
      run_instr(32'h0050_0093, 0, 0, 0, 0, 1'b0, 0);
      run_instr(32'h0050_0093, 2, TIMEOUT, 0, 0, 1'b0, 0);
      check_frozen(5);
      do_reset();
   endtask

   task automatic test_mid_reset();
      run_instr(32'h0050_0093, 0, 0, 0, 0, 1'b0, 0);
      run_instr(32'h0000_A103, 0, 0, 0, 10, 1'b0, 8);
      #1;
      vecs++;
      if ({imem_req_valid, dmem_req_valid, pc_we, rf_we} !== 4'b0000) begin
         errs++;
         $display("FAIL midrst_gate got %b want 0000", {imem_req_valid, dmem_req_valid, pc_we, rf_we});
      end
      @(negedge clk);
      vecs++;
      if (state !== ST_IF_REQ || cycle_cnt !== '0 || instret_cnt !== '0 || ir !== 32'h0 ||
          {imem_req_valid, dmem_req_valid, pc_we, rf_we} !== 4'b0000) begin
         errs++;
         $display("FAIL midrst_state got st=%0d cyc=%0d ret=%0d ir=%h strb=%b want 0/0/0/0/0000",
                  state, cycle_cnt, instret_cnt, ir, {imem_req_valid, dmem_req_valid, pc_we, rf_we});
      end
      do_reset();
      run_instr(32'h0050_0093, 0, 0, 0, 0, 1'b0, 0);
   endtask

   task automatic test_illegal();
      bit mem, wr, trap, ill;
      run_instr(32'h0000_007F, 0, 0, 0, 0, 1'b0, 0);
      check_frozen(3);
      for (int i = 0; i < 4; i++) begin
         logic [6:0] op;
         do begin
            op = 7'($urandom);
            classify(op, mem, wr, trap, ill);
         end while (!ill);
         do_reset();
         run_instr(rand_inst(op), $urandom_range(2), $urandom_range(3), 0, 0, 1'b0, 0);
         check_frozen(2);
      end
   endtask

   initial begin
      rst = 1'b0;
      idle_inputs();
      test_reset();
      test_alu();
      test_mem();
      test_back_to_back();
      test_ebreak();
      test_timeout();
      test_mid_reset();
      test_illegal();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
